// File: rtl/op_share_arbiter_bw16_req4.sv
// Round-robin arbiter sharing one ST/RD/RES operation unit among four requesters.
// Optional watchdog on the unit's completion is enabled by defining OP_ARB_TIMEOUT_EN.
module op_share_arbiter_bw16_req4 #(
  parameter int unsigned BW      = 16,
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NREQ-1:0]    i_req,
  input  logic [NREQ*BW-1:0] i_req_in0,
  input  logic [NREQ*BW-1:0] i_req_in1,
  input  logic [NREQ*BW-1:0] i_req_in2,
  output logic [NREQ-1:0]    o_rd,
  output logic [NREQ*BW-1:0] o_res,
  output logic [NREQ-1:0]    o_err,
  output logic               o_op_st,
  output logic [BW-1:0]      o_op_in0,
  output logic [BW-1:0]      o_op_in1,
  output logic [BW-1:0]      o_op_in2,
  input  logic               i_op_rd,
  input  logic [BW-1:0]      i_op_res
);

  typedef enum logic [1:0] {StIdle, StStart, StWait} state_e;

  state_e            r_state, w_state_d;
  logic [NREQ-1:0]   r_pending, w_pending_d;
  logic [1:0]        r_ptr, w_ptr_d;
  logic [1:0]        r_winner, w_winner_d;
  logic [NREQ-1:0]   r_req_old;
  logic              r_op_rd_old;
  logic [NREQ-1:0]   r_rd, w_rd_d;
  logic [NREQ*BW-1:0] r_res, w_res_d;
  logic              r_op_st, w_op_st_d;
  logic [BW-1:0]     r_op_in0, w_op_in0_d;
  logic [BW-1:0]     r_op_in1, w_op_in1_d;
  logic [BW-1:0]     r_op_in2, w_op_in2_d;

  logic [NREQ-1:0]   w_req_edge;
  logic              w_done;
  logic              w_grant_vld;
  logic [1:0]        w_grant_idx;
  logic [1:0]        w_cand;

  // An edge only counts while the requester is idle, using RD before this cycle's update.
  assign w_req_edge = i_req & ~r_req_old & r_rd;
  assign w_done     = ~r_op_rd_old & i_op_rd;

`ifdef OP_ARB_TIMEOUT_EN
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);
  logic [15:0]     r_cnt, w_cnt_d;
  logic [NREQ-1:0] r_err, w_err_d;
  assign o_err = r_err;
`else
  logic [31:0] w_unused_timeout;
  assign w_unused_timeout = 32'(TIMEOUT);
  assign o_err = '0;
`endif

  // First pending index at or after the pointer, cyclically.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = r_ptr;
    w_cand      = r_ptr;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_cand = r_ptr + 2'(k);
      if (r_pending[w_cand]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = w_cand;
      end
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_pending_d = r_pending | w_req_edge;
    w_ptr_d     = r_ptr;
    w_winner_d  = r_winner;
    w_rd_d      = r_rd & ~w_req_edge;
    w_res_d     = r_res;
    w_op_st_d   = r_op_st;
    w_op_in0_d  = r_op_in0;
    w_op_in1_d  = r_op_in1;
    w_op_in2_d  = r_op_in2;
`ifdef OP_ARB_TIMEOUT_EN
    w_cnt_d     = r_cnt;
    w_err_d     = r_err & ~w_req_edge;
`endif
    case (r_state)
      StIdle: begin
        if (w_grant_vld) begin
          w_winner_d = w_grant_idx;
          w_op_in0_d = i_req_in0[w_grant_idx*BW +: BW];
          w_op_in1_d = i_req_in1[w_grant_idx*BW +: BW];
          w_op_in2_d = i_req_in2[w_grant_idx*BW +: BW];
          w_op_st_d  = 1'b1;
          w_state_d  = StStart;
`ifdef OP_ARB_TIMEOUT_EN
          w_cnt_d    = '0;
`endif
        end
      end
      // Start stays high through this cycle; it drops on the first WAIT edge.
      StStart: w_state_d = StWait;
      StWait: begin
        w_op_st_d = 1'b0;
        if (w_done) begin
          w_res_d[r_winner*BW +: BW] = i_op_res;
          w_rd_d[r_winner]           = 1'b1;
          w_pending_d[r_winner]      = 1'b0;
          w_ptr_d                    = r_winner + 2'd1;
          w_state_d                  = StIdle;
        end
`ifdef OP_ARB_TIMEOUT_EN
        else if (r_cnt == TimeoutLast) begin
          w_res_d[r_winner*BW +: BW] = {BW{1'b1}};
          w_err_d[r_winner]          = 1'b1;
          w_rd_d[r_winner]           = 1'b1;
          w_pending_d[r_winner]      = 1'b0;
          w_ptr_d                    = r_winner + 2'd1;
          w_state_d                  = StIdle;
        end else begin
          w_cnt_d = r_cnt + 16'd1;
        end
`endif
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_pending   <= '0;
      r_ptr       <= '0;
      r_winner    <= '0;
      r_req_old   <= '0;
      r_op_rd_old <= 1'b0;
      r_rd        <= '1;
      r_res       <= '0;
      r_op_st     <= 1'b0;
      r_op_in0    <= '0;
      r_op_in1    <= '0;
      r_op_in2    <= '0;
`ifdef OP_ARB_TIMEOUT_EN
      r_cnt       <= '0;
      r_err       <= '0;
`endif
    end else begin
      r_state     <= w_state_d;
      r_pending   <= w_pending_d;
      r_ptr       <= w_ptr_d;
      r_winner    <= w_winner_d;
      r_req_old   <= i_req;
      r_op_rd_old <= i_op_rd;
      r_rd        <= w_rd_d;
      r_res       <= w_res_d;
      r_op_st     <= w_op_st_d;
      r_op_in0    <= w_op_in0_d;
      r_op_in1    <= w_op_in1_d;
      r_op_in2    <= w_op_in2_d;
`ifdef OP_ARB_TIMEOUT_EN
      r_cnt       <= w_cnt_d;
      r_err       <= w_err_d;
`endif
    end
  end

  assign o_rd     = r_rd;
  assign o_res    = r_res;
  assign o_op_st  = r_op_st;
  assign o_op_in0 = r_op_in0;
  assign o_op_in1 = r_op_in1;
  assign o_op_in2 = r_op_in2;

endmodule

// File: tb/tb_op_share_arbiter_bw16_req4.sv
// Scoreboard bench for op_share_arbiter_bw16_req4 with a behavioural adder unit.
module tb_op_share_arbiter_bw16_req4;

  localparam int BW = 16;

  typedef struct {
    logic [1:0]    idx;
    logic [BW-1:0] in0;
    logic [BW-1:0] in1;
    logic [BW-1:0] in2;
    logic [BW-1:0] res;
  } job_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    req = '0;
  logic [4*BW-1:0] req_in0 = '0, req_in1 = '0, req_in2 = '0;
  logic [3:0]    rd, err;
  logic [4*BW-1:0] res;
  logic          op_st;
  logic [BW-1:0] op_in0, op_in1, op_in2;
  logic          op_rd = 1'b1;
  logic [BW-1:0] op_res = '0;

  int   checks = 0;
  int   errors = 0;
  job_t sb[$];
  job_t mon_e;
  bit   mon_en = 1'b0;
  bit   gap_check = 1'b0;
  int   grant_cnt = 0;
  int   cyc = 0;
  int   last_done_cyc = -1;
  int   st_len = 0;
  logic st_prev = 1'b0;
  logic [3:0] rd_prev = 4'hF;

  // Unit model
  int   lat = 6;
  bit   hang_once = 1'b0;
  bit   m_busy = 1'b0, m_hang = 1'b0;
  int   m_cnt = 0;
  logic m_st_q = 1'b0;

  op_share_arbiter_bw16_req4 #(.BW(16), .NREQ(4), .TIMEOUT(20)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req),
    .i_req_in0(req_in0), .i_req_in1(req_in1), .i_req_in2(req_in2),
    .o_rd(rd), .o_res(res), .o_err(err), .o_op_st(op_st),
    .o_op_in0(op_in0), .o_op_in1(op_in1), .o_op_in2(op_in2),
    .i_op_rd(op_rd), .i_op_res(op_res)
  );

  always #5 clk = ~clk;

  // Rising start restarts the unit; result is the 16-bit sum of the operands.
  always @(posedge clk) begin
    m_st_q <= op_st;
    if (op_st && !m_st_q) begin
      m_busy    <= 1'b1;
      m_hang    <= hang_once;
      hang_once <= 1'b0;
      m_cnt     <= lat - 1;
      op_rd     <= 1'b0;
      op_res    <= op_in0 + op_in1 + op_in2;
    end else if (m_busy && !m_hang) begin
      if (m_cnt == 0) begin
        op_rd  <= 1'b1;
        m_busy <= 1'b0;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  // Grant / completion monitor against the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      if (op_st && !st_prev) begin
        grant_cnt++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL grant_unexpected: got grant with operands %h/%h/%h, required none",
                   op_in0, op_in1, op_in2);
        end else if ({op_in0, op_in1, op_in2} !== {sb[0].in0, sb[0].in1, sb[0].in2}) begin
          errors++;
          $display("FAIL grant_operands: got %h/%h/%h, required %h/%h/%h", op_in0, op_in1,
                   op_in2, sb[0].in0, sb[0].in1, sb[0].in2);
        end
        if (gap_check && last_done_cyc >= 0) begin
          checks++;
          if (cyc - last_done_cyc != 1) begin
            errors++;
            $display("FAIL idle_gap: got %0d, required 1", cyc - last_done_cyc);
          end
        end
      end
      if (!op_st && st_prev) begin
        checks++;
        if (st_len != 2) begin
          errors++;
          $display("FAIL op_st_width: got %0d cycles, required 2", st_len);
        end
      end
      for (int j = 0; j < 4; j++) begin
        if (rd[j] && !rd_prev[j]) begin
          last_done_cyc = cyc;
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL done_unexpected: got completion on %0d, required none", j);
          end else begin
            mon_e = sb.pop_front();
            if (mon_e.idx != 2'(j) || res[j*BW +: BW] !== mon_e.res) begin
              errors++;
              $display("FAIL completion: got slot %0d res %h, required slot %0d res %h", j,
                       res[j*BW +: BW], mon_e.idx, mon_e.res);
            end
          end
        end
      end
    end
    st_len  = op_st ? (st_prev ? st_len + 1 : 1) : 0;
    st_prev = op_st;
    rd_prev = rd;
    cyc++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    rst_n  = 1'b0;
    tick(1);
    rst_n  = 1'b1;
    sb.delete();
    tick(1);
    mon_en = 1'b1;
  endtask

  task automatic raise_req(input logic [3:0] m);
    req = req | m;
    tick(1);
    req = req & ~m;
  endtask

  task automatic set_ops(input int i, input logic [BW-1:0] a, input logic [BW-1:0] b,
                         input logic [BW-1:0] c);
    job_t e;
    req_in0[i*BW +: BW] = a;
    req_in1[i*BW +: BW] = b;
    req_in2[i*BW +: BW] = c;
    e.idx = 2'(i); e.in0 = a; e.in1 = b; e.in2 = c; e.res = a + b + c;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(2);
    checks += 5;
    if (rd !== 4'hF) begin errors++; $display("FAIL reset_rd: got %b, required 1111", rd); end
    if (res !== '0) begin errors++; $display("FAIL reset_res: got %h, required 0", res); end
    if (err !== 4'h0) begin errors++; $display("FAIL reset_err: got %b, required 0000", err); end
    if (op_st !== 1'b0) begin errors++; $display("FAIL reset_op_st: got %b, required 0", op_st); end
    if ({op_in0, op_in1, op_in2} !== '0) begin
      errors++;
      $display("FAIL reset_op_in: got %h/%h/%h, required 0", op_in0, op_in1, op_in2);
    end
    rst_n = 1'b1;
    tick(1);
    mon_en = 1'b1;
  endtask

  task automatic test_single();
    int c;
    set_ops(2, 16'd5, 16'd7, 16'd0);
    raise_req(4'b0100);
    checks++;
    if (rd !== 4'b1011) begin errors++; $display("FAIL single_rd_low: got %b, required 1011", rd); end
    for (c = 0; c < 100 && !(rd === 4'hF && sb.size() == 0); c++) tick(1);
    checks += 3;
    if (c >= 100) begin errors++; $display("FAIL single_timeout: got busy, required done"); end
    if (res[2*BW +: BW] !== 16'd12) begin
      errors++; $display("FAIL single_res: got %0d, required 12", res[2*BW +: BW]);
    end
    if ({op_in0, op_in1} !== {16'd5, 16'd7}) begin
      errors++; $display("FAIL single_op_hold: got %0d/%0d, required 5/7", op_in0, op_in1);
    end
  endtask

  task automatic test_all_four();
    int c;
    logic [BW-1:0] exp_res[4];
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_ops(i, 16'($urandom), 16'($urandom), 16'($urandom));
      exp_res[i] = sb[i].res;
    end
    last_done_cyc = -1;
    gap_check = 1'b1;
    raise_req(4'hF);
    for (c = 0; c < 300 && !(rd === 4'hF && sb.size() == 0); c++) tick(1);
    gap_check = 1'b0;
    checks++;
    if (c >= 300) begin errors++; $display("FAIL all_four_timeout: got rd %b, required 1111", rd); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (res[i*BW +: BW] !== exp_res[i]) begin
        errors++;
        $display("FAIL all_four_slot%0d: got %h, required %h", i, res[i*BW +: BW], exp_res[i]);
      end
    end
  endtask

  task automatic test_wrap();
    int c;
    do_reset();
    set_ops(2, 16'd1, 16'd2, 16'd3);
    raise_req(4'b0100);
    for (c = 0; c < 100 && !(rd === 4'hF && sb.size() == 0); c++) tick(1);
    set_ops(3, 16'h0100, 16'h0020, 16'h0003);
    set_ops(0, 16'h1000, 16'h0200, 16'h0030);
    raise_req(4'b1001);
    for (c = 0; c < 200 && !(rd === 4'hF && sb.size() == 0); c++) tick(1);
    checks += 3;
    if (c >= 200) begin errors++; $display("FAIL wrap_timeout: got rd %b, required 1111", rd); end
    if (res[3*BW +: BW] !== 16'h0123) begin
      errors++; $display("FAIL wrap_slot3: got %h, required 0123", res[3*BW +: BW]);
    end
    if (res[0 +: BW] !== 16'h1230) begin
      errors++; $display("FAIL wrap_slot0: got %h, required 1230", res[0 +: BW]);
    end
  endtask

  task automatic test_ignored_edge();
    int c, g0;
    g0 = grant_cnt;
    set_ops(1, 16'd40, 16'd2, 16'd0);
    raise_req(4'b0010);
    tick(3);
    checks++;
    if (rd[1] !== 1'b0) begin errors++; $display("FAIL ignored_busy: got rd1 %b, required 0", rd[1]); end
    raise_req(4'b0010);
    for (c = 0; c < 100 && !(rd === 4'hF && sb.size() == 0); c++) tick(1);
    tick(20);
    checks += 2;
    if (grant_cnt - g0 != 1) begin
      errors++; $display("FAIL ignored_jobs: got %0d, required 1", grant_cnt - g0);
    end
    if (res[1*BW +: BW] !== 16'd42) begin
      errors++; $display("FAIL ignored_res: got %0d, required 42", res[1*BW +: BW]);
    end
  endtask

  task automatic test_reset_mid_wait();
    int c, g0;
    set_ops(0, 16'd9, 16'd9, 16'd9);
    raise_req(4'b0001);
    for (c = 0; c < 20 && !(op_st === 1'b0 && op_rd === 1'b0); c++) tick(1);
    tick(1);
    mon_en = 1'b0;
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    sb.delete();
    checks += 3;
    if (rd !== 4'hF) begin errors++; $display("FAIL midrst_rd: got %b, required 1111", rd); end
    if (res !== '0) begin errors++; $display("FAIL midrst_res: got %h, required 0", res); end
    if (op_st !== 1'b0) begin errors++; $display("FAIL midrst_op_st: got %b, required 0", op_st); end
    tick(1);
    mon_en = 1'b1;
    g0 = grant_cnt;
    for (c = 0; c < 50 && op_rd !== 1'b1; c++) tick(1);
    tick(5);
    checks += 3;
    if (op_rd !== 1'b1) begin errors++; $display("FAIL midrst_unit: got op_rd 0, required 1"); end
    if (res !== '0 || rd !== 4'hF) begin
      errors++; $display("FAIL midrst_late: got res %h rd %b, required 0/1111", res, rd);
    end
    if (grant_cnt != g0) begin
      errors++; $display("FAIL midrst_grant: got %0d grants, required 0", grant_cnt - g0);
    end
  endtask

`ifdef OP_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int c;
    job_t e;
    do_reset();
    hang_once = 1'b1;
    set_ops(1, 16'd1, 16'd1, 16'd1);
    sb[sb.size()-1].res = 16'hFFFF;
    set_ops(2, 16'd2, 16'd2, 16'd2);
    raise_req(4'b0110);
    for (c = 0; c < 300 && !(rd === 4'hF && sb.size() == 0); c++) tick(1);
    checks += 3;
    if (c >= 300) begin errors++; $display("FAIL timeout_done: got rd %b, required 1111", rd); end
    if (err !== 4'b0010) begin errors++; $display("FAIL timeout_err: got %b, required 0010", err); end
    if (res[2*BW +: BW] !== 16'd6) begin
      errors++; $display("FAIL timeout_next: got %0d, required 6", res[2*BW +: BW]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_wrap();
    test_ignored_edge();
    test_reset_mid_wait();
`ifdef OP_ARB_TIMEOUT_EN
    test_timeout();
`else
    checks++;
    if (err !== 4'h0) begin errors++; $display("FAIL err_const: got %b, required 0000", err); end
`endif
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL sb_leftover: got %0d entries, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, required finish");
    $fatal(1);
  end

endmodule

// File: doc/op_share_arbiter_bw16_req4.md
# op_share_arbiter_bw16_req4

Round-robin scheduler that shares one operation unit (ST/RD/RES handshake, three 16-bit operand inputs) among four requesters. Each requester sees its own ST/RD/RES-style handshake. The arbiter latches the winner's operands, sequences the unit's start pulse, waits for completion and returns the result to the winner's result slot. It sits between composition/minimisation wrappers and a single costly operation instance, so that instance need not be replicated.

## Interface
- BW, 16: operand/result width
- NREQ, 4: requester count (fixed 4 in this revision)
- TIMEOUT, 1024: watchdog limit in cycles (used only with OP_ARB_TIMEOUT_EN)

- CLK  input  1  clock; all logic on posedge
- RST  input  1  synchronous, active-low reset
- REQ  input  4  per-requester start; rising edge requests service
- REQ_IN0 / REQ_IN1 / REQ_IN2  input  4*BW  packed operands; slot i = bits [i*BW +: BW]
- RD  output  4  per-requester ready; 1 = idle/result valid, 0 = pending or in service
- RES  output  4*BW  packed result slots, one per requester
- ERR  output  4  per-requester timeout flag (held 0 without OP_ARB_TIMEOUT_EN)
- OP_ST  output  1  start to shared unit
- OP_IN0 / OP_IN1 / OP_IN2  output  BW  operands to shared unit
- OP_RD  input  1  shared unit ready
- OP_RES  input  BW  shared unit result

## Operation
- Reset (RST=0 at posedge):
  - RD=4'b1111, RES=0, ERR=0, OP_ST=0, OP_IN*=0.
  - Pending=0, pointer=0, REQold=0, OP_RDold=0, state IDLE.
  - The shared unit's own reset is driven outside this block.
- Request capture:
  - REQ[i]=1 with REQold[i]=0 and RD[i]=1 sets pending[i], clears RD[i] and ERR[i].
  - An edge while RD[i]=0 is ignored.
- Operand latching: operands are sampled at grant, not at request. A requester holds REQ_IN* stable until its RD rises.
- States:
  - IDLE: if any pending, grant the first pending index at or after the pointer (cyclic). Latch that slot's operands into OP_IN*, set OP_ST=1, record the winner, go to START.
  - START: OP_ST held 1 for a second cycle, then cleared; go to WAIT.
  - WAIT: on OP_RDold=0 and OP_RD=1:
    - RES[winner]=OP_RES, RD[winner]=1, pending[winner]=0.
    - pointer=(winner+1) mod 4.
    - go to IDLE.
- OP_IN* hold the latched operands until the next grant.
- Simultaneous events:
  - A new request edge on another requester while the unit is busy only sets pending.
  - Completion and a REQ edge from the winner in the same cycle: the edge is ignored (RD still 0 at sampling).
- Reset mid-operation forces the reset state. An in-flight result is discarded.

## Timing
- Edge at cycle n (REQ sampled high) -> RD[i]=0 visible after posedge n.
- Grant at posedge n+1 when idle; OP_ST=1 for posedges n+1..n+2, 0 from n+3.
- Completion detected at the posedge where OP_RD is sampled 1 after 0. RES/RD update at that edge.
- The earliest next grant is the following posedge (one idle cycle between jobs).
- Arbiter overhead per job: 3 cycles plus unit latency.
- Fairness: with all four pending, service order is pointer, pointer+1, ...; no requester waits more than 3 jobs.

## Configuration
- OP_ARB_TIMEOUT_EN defined:
  - A 16-bit cycle counter runs in WAIT.
  - On reaching TIMEOUT without completion: RES[winner]={BW{1'b1}}, ERR[winner]=1, RD[winner]=1, pending cleared, pointer advanced, state IDLE.
  - A late OP_RD rise is then ignored, because it is outside WAIT.
- Undefined: no counter. WAIT lasts until OP_RD rises. ERR is constant 0.

## Test plan
- Single request: REQ[2] edge with IN0=5, IN1=7, IN2=0; unit model returns OP_RES=12 after 6 cycles -> OP_IN0=5, OP_IN1=7, OP_ST high exactly 2 cycles, RES slot 2=12, RD=4'b1111.
- All four request in the same cycle, pointer=0 -> grants in order 0,1,2,3; each result lands in its own slot; one idle cycle between jobs.
- Fairness wrap: pointer=3, pending {0,3} -> grant 3 then 0.
- Ignored edge: REQ[1] toggled 0->1 again while RD[1]=0 -> exactly one job for requester 1.
- Reset mid-WAIT: RST=0 one cycle -> RD=4'b1111, RES=0, OP_ST=0; a later OP_RD rise updates no slot.
- With OP_ARB_TIMEOUT_EN, TIMEOUT=20, unit never completes -> after 20 WAIT cycles RES slot=16'hFFFF, ERR[i]=1, RD[i]=1; the next pending requester is granted.
